// File: rtl/slot_game_fsm.sv
// Slot-machine game controller: credit, bet, three-reel spin/stop sequencing, win payout.
// Optional reel auto-stop timeout is compiled in when SLOT_AUTOSTOP_EN is defined.
module slot_game_fsm #(
    parameter logic [9:0] INIT_CREDIT  = 10'd100,
    parameter int         REEL_DIV     = 4,
    parameter int         AUTO_TIMEOUT = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_bet,
    input  logic       btn_spin,
    input  logic       btn_stop,
    output logic [9:0] credit,
    output logic [1:0] bet,
    output logic [1:0] reel0,
    output logic [1:0] reel1,
    output logic [1:0] reel2,
    output logic [2:0] spinning,
    output logic       stop,
    output logic       win,
    output logic [5:0] payout_left
);

    typedef enum logic [1:0] {IDLE, SPIN, EVAL, PAY} state_t;

    localparam logic [9:0] CREDIT_MAX = 10'd999;

    state_t     state_reg, state_next;
    logic [2:0] btn_reg, btn_prev_reg;
    logic [9:0] credit_reg, credit_next;
    logic [1:0] bet_reg, bet_next;
    logic [2:0] spinning_reg, spinning_next;
    logic       stop_reg;
    logic       win_reg, win_next;
    logic [5:0] payout_reg, payout_next;
    logic [3:0] presc_reg, presc_next;
    logic [5:0] reel_vec_reg, reel_vec_next;
    logic       advance;
    logic       auto_stop;
    logic [2:0] stop_mask;
    logic [5:0] mult_sym;
    logic [5:0] payout_calc;

    // Presses come from the registered sample and its delayed copy, so held levels act once.
    logic bet_press, spin_press, stop_press;
    assign bet_press  = btn_reg[0] & ~btn_prev_reg[0];
    assign spin_press = btn_reg[1] & ~btn_prev_reg[1];
    assign stop_press = btn_reg[2] & ~btn_prev_reg[2];

    // Lowest still-spinning reel is the one a stop request freezes.
    assign stop_mask = spinning_reg & (~spinning_reg + 3'd1);

    always_comb begin
        mult_sym = 6'd2;
        case (reel_vec_reg[1:0])
            2'd0: mult_sym = 6'd2;
            2'd1: mult_sym = 6'd5;
            2'd2: mult_sym = 6'd10;
            2'd3: mult_sym = 6'd20;
            default: mult_sym = 6'd2;
        endcase
    end
    assign payout_calc = mult_sym * {4'd0, bet_reg};

`ifdef SLOT_AUTOSTOP_EN
    logic [15:0] tmo_reg, tmo_next;

    always_comb begin
        tmo_next  = '0;
        auto_stop = 1'b0;
        if (state_reg == SPIN) begin
            tmo_next = tmo_reg;
            if (stop_press) begin
                tmo_next = '0;
            end else if (frame_tick) begin
                if (tmo_reg == 16'(AUTO_TIMEOUT - 1)) begin
                    auto_stop = 1'b1;
                    tmo_next  = '0;
                end else begin
                    tmo_next = tmo_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_reg <= '0;
        else     tmo_reg <= tmo_next;
    end
`else
    assign auto_stop = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        bet_next      = bet_reg;
        spinning_next = spinning_reg;
        win_next      = win_reg;
        payout_next   = payout_reg;
        presc_next    = presc_reg;
        advance       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (spin_press && (credit_reg >= {8'd0, bet_reg})) begin
                    credit_next   = credit_reg - {8'd0, bet_reg};
                    spinning_next = 3'b111;
                    win_next      = 1'b0;
                    presc_next    = '0;
                    state_next    = SPIN;
                end else if (bet_press) begin
                    bet_next = (bet_reg == 2'd3) ? 2'd1 : bet_reg + 2'd1;
                end
            end
            SPIN: begin
                if (stop_press || auto_stop) spinning_next = spinning_reg & ~stop_mask;
                if (frame_tick) begin
                    if (presc_reg == 4'(REEL_DIV - 1)) begin
                        advance    = 1'b1;
                        presc_next = '0;
                    end else begin
                        presc_next = presc_reg + 4'd1;
                    end
                end
                if (spinning_next == 3'b000) state_next = EVAL;
            end
            EVAL: begin
                if ((reel_vec_reg[1:0] == reel_vec_reg[3:2]) &&
                    (reel_vec_reg[3:2] == reel_vec_reg[5:4])) begin
                    win_next    = 1'b1;
                    payout_next = payout_calc;
                    state_next  = PAY;
                end else begin
                    state_next = IDLE;
                end
            end
            PAY: begin
                if (frame_tick) begin
                    credit_next = (credit_reg >= CREDIT_MAX) ? CREDIT_MAX : credit_reg + 10'd1;
                    payout_next = payout_reg - 6'd1;
                    // Saturating at 999 forfeits whatever payout remains.
                    if ((payout_reg <= 6'd1) || (credit_reg >= CREDIT_MAX - 10'd1)) begin
                        payout_next = '0;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A reel moves only if it is still spinning after this cycle's stop request.
    for (genvar gi = 0; gi < 3; gi++) begin : g_reel
        assign reel_vec_next[2*gi +: 2] = (advance && spinning_next[gi])
                                          ? reel_vec_reg[2*gi +: 2] + 2'd1
                                          : reel_vec_reg[2*gi +: 2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            btn_reg      <= '0;
            btn_prev_reg <= '0;
            credit_reg   <= INIT_CREDIT;
            bet_reg      <= 2'd1;
            spinning_reg <= '0;
            stop_reg     <= 1'b1;
            win_reg      <= 1'b0;
            payout_reg   <= '0;
            presc_reg    <= '0;
            reel_vec_reg <= '0;
        end else begin
            state_reg    <= state_next;
            btn_reg      <= {btn_stop, btn_spin, btn_bet};
            btn_prev_reg <= btn_reg;
            credit_reg   <= credit_next;
            bet_reg      <= bet_next;
            spinning_reg <= spinning_next;
            stop_reg     <= (spinning_next == 3'b000);
            win_reg      <= win_next;
            payout_reg   <= payout_next;
            presc_reg    <= presc_next;
            reel_vec_reg <= reel_vec_next;
        end
    end

    assign credit      = credit_reg;
    assign bet         = bet_reg;
    assign reel0       = reel_vec_reg[1:0];
    assign reel1       = reel_vec_reg[3:2];
    assign reel2       = reel_vec_reg[5:4];
    assign spinning    = spinning_reg;
    assign stop        = stop_reg;
    assign win         = win_reg;
    assign payout_left = payout_reg;

endmodule

// File: tb/tb_slot_game_fsm.sv
// Directed bench for slot_game_fsm: betting, spinning, stopping, payout, saturation, reset.
// Define SLOT_AUTOSTOP_EN for both bench and RTL to exercise the auto-stop timeout.
module tb_slot_game_fsm;

    logic       clk, rst, frame_tick, btn_bet, btn_spin, btn_stop;
    logic [9:0] credit, credit_z;
    logic [1:0] bet, reel0, reel1, reel2, bet_z, reel0_z, reel1_z, reel2_z;
    logic [2:0] spinning, spinning_z;
    logic       stop, win, stop_z, win_z;
    logic [5:0] payout_left, payout_left_z;

    int n_total = 0;
    int n_bad   = 0;
    int m_credit, m_bet, m_sym;

    slot_game_fsm #(.INIT_CREDIT(10'd100), .REEL_DIV(4), .AUTO_TIMEOUT(5)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_bet(btn_bet), .btn_spin(btn_spin), .btn_stop(btn_stop),
        .credit(credit), .bet(bet), .reel0(reel0), .reel1(reel1), .reel2(reel2),
        .spinning(spinning), .stop(stop), .win(win), .payout_left(payout_left)
    );

    // Second instance starts broke: every spin press it sees must be ignored.
    slot_game_fsm #(.INIT_CREDIT(10'd0), .REEL_DIV(4), .AUTO_TIMEOUT(5)) dut_zero (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_bet(btn_bet), .btn_spin(btn_spin), .btn_stop(btn_stop),
        .credit(credit_z), .bet(bet_z), .reel0(reel0_z), .reel1(reel1_z), .reel2(reel2_z),
        .spinning(spinning_z), .stop(stop_z), .win(win_z), .payout_left(payout_left_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic int mult_of(input int s);
        case (s)
            0: return 2;
            1: return 5;
            2: return 10;
            default: return 20;
        endcase
    endfunction

    // which: 0 bet, 1 spin, 2 stop, 3 bet+spin together
    task automatic press(input int which, input int hold);
        @(negedge clk);
        btn_bet  = (which == 0) || (which == 3);
        btn_spin = (which == 1) || (which == 3);
        btn_stop = (which == 2);
        repeat (hold) @(negedge clk);
        btn_bet = 1'b0; btn_spin = 1'b0; btn_stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            frame_tick = 1'b1;
        end
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic bet_press;
        press(0, 1);
        m_bet = (m_bet == 3) ? 1 : m_bet + 1;
        check_eq("bet_cycle", int'(bet), m_bet);
        $display("bet press: bet=%0d", bet);
    endtask

    // Reels share one symbol: spin, advance n_adv symbols, stop all three, collect payout.
    task automatic play_win(input int n_adv);
        int pay, amt;
        press(1, 1);
        m_credit -= m_bet;
        check_eq("spin_credit", int'(credit), m_credit);
        check_eq("spin_mask", int'(spinning), 7);
        tick_n(4 * n_adv);
        m_sym = (m_sym + n_adv) % 4;
        repeat (3) press(2, 1);
        @(negedge clk);
        amt = m_bet * mult_of(m_sym);
        check_eq("win_flag", int'(win), 1);
        check_eq("win_payout", int'(payout_left), amt);
        pay = (amt < 999 - m_credit) ? amt : 999 - m_credit;
        tick_n(pay - 1);
        check_eq("pay_credit_mid", int'(credit), m_credit + pay - 1);
        check_eq("pay_left_mid", int'(payout_left), amt - pay + 1);
        tick_n(1);
        m_credit += pay;
        check_eq("pay_credit_end", int'(credit), m_credit);
        check_eq("pay_left_end", int'(payout_left), 0);
        tick_n(2);
        check_eq("idle_credit_hold", int'(credit), m_credit);
        $display("win spin: sym=%0d bet=%0d paid=%0d credit=%0d", m_sym, m_bet, pay, credit);
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0;
        btn_bet = 1'b0; btn_spin = 1'b0; btn_stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_credit", int'(credit), 100);
        check_eq("rst_bet", int'(bet), 1);
        check_eq("rst_reels", int'({reel2, reel1, reel0}), 0);
        check_eq("rst_stop", int'(stop), 1);
        check_eq("rst_win", int'(win), 0);
        $display("reset: credit=%0d bet=%0d stop=%0d", credit, bet, stop);
        m_credit = 100; m_bet = 1; m_sym = 0;

        // Bet cycling; the second press is held for several cycles and still counts once.
        bet_press();
        press(0, 6);
        m_bet = 3;
        check_eq("bet_held", int'(bet), 3);
        bet_press();
        bet_press();
        bet_press();

        // Losing spin with bet 3, reels stopped at different symbols.
        press(1, 1);
        check_eq("spin_credit", int'(credit), 97);
        check_eq("spin_mask", int'(spinning), 7);
        check_eq("spin_stop_low", int'(stop), 0);
        check_eq("zero_credit_ignored", int'(credit_z), 0);
        check_eq("zero_spin_ignored", int'(spinning_z), 0);
        tick_n(8);
        check_eq("adv8_reels", int'({reel2, reel1, reel0}), 6'b10_10_10);
        press(2, 1);
        check_eq("stop1_mask", int'(spinning), 6);
        tick_n(4);
        check_eq("stop1_reels", int'({reel2, reel1, reel0}), 6'b11_11_10);
        press(2, 1);
        check_eq("stop2_mask", int'(spinning), 4);
        tick_n(4);
        press(2, 1);
        check_eq("stop3_mask", int'(spinning), 0);
        check_eq("stop3_stop", int'(stop), 1);
        @(negedge clk);
        check_eq("lose_reels", int'({reel2, reel1, reel0}), 6'b00_11_10);
        check_eq("lose_win", int'(win), 0);
        check_eq("lose_credit", int'(credit), 97);
        $display("lose spin: reels=%0d,%0d,%0d credit=%0d", reel0, reel1, reel2, credit);

        // Steer every reel onto symbol 3 with bet 2.
        bet_press();
        bet_press();
        press(1, 1);
        check_eq("spin2_credit", int'(credit), 95);
        tick_n(4);
        press(2, 1);
        tick_n(12);
        press(2, 1);
        tick_n(12);
        press(2, 1);
        @(negedge clk);
        check_eq("sym3_reels", int'({reel2, reel1, reel0}), 6'b11_11_11);
        check_eq("sym3_win", int'(win), 1);
        check_eq("sym3_payout", int'(payout_left), 40);
        tick_n(40);
        check_eq("sym3_credit", int'(credit), 135);
        check_eq("sym3_left", int'(payout_left), 0);
        check_eq("win_held", int'(win), 1);
        $display("win spin: sym=3 bet=2 credit=%0d", credit);
        m_credit = 135; m_sym = 3;

        // Climb to 980 credits, then a 60-credit win saturates at 999.
        bet_press();
        repeat (14) play_win(4);
        bet_press();
        play_win(3);
        bet_press();
        play_win(1);
        check_eq("pre_sat_credit", int'(credit), 980);
        bet_press();
        play_win(0);
        check_eq("sat_credit", int'(credit), 999);

        // Reset while paying out.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("rst2_credit", int'(credit), 100);
        check_eq("rst2_bet", int'(bet), 1);
        press(3, 1);
        check_eq("both_bet", int'(bet), 1);
        check_eq("both_credit", int'(credit), 99);
        repeat (3) press(2, 1);
        @(negedge clk);
        check_eq("sym0_payout", int'(payout_left), 2);
        tick_n(1);
        check_eq("pay1_credit", int'(credit), 100);
        check_eq("pay1_left", int'(payout_left), 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("midpay_rst_left", int'(payout_left), 0);
        check_eq("midpay_rst_win", int'(win), 0);
        check_eq("midpay_rst_stop", int'(stop), 1);
        $display("reset mid-pay: credit=%0d win=%0d payout_left=%0d", credit, win, payout_left);
        m_credit = 100; m_bet = 1; m_sym = 0;
        bet_press();

        press(1, 1);
        m_credit -= m_bet;
        check_eq("auto_spin_credit", int'(credit), m_credit);
`ifdef SLOT_AUTOSTOP_EN
        tick_n(4);
        check_eq("auto_4", int'(spinning), 7);
        tick_n(1);
        check_eq("auto_5", int'(spinning), 6);
        tick_n(5);
        check_eq("auto_10", int'(spinning), 4);
        tick_n(5);
        check_eq("auto_15", int'(spinning), 0);
        check_eq("auto_stop", int'(stop), 1);
        @(negedge clk);
        check_eq("auto_reels", int'({reel2, reel1, reel0}), 6'b11_10_01);
        check_eq("auto_win", int'(win), 0);
        $display("auto-stop: reels=%0d,%0d,%0d", reel0, reel1, reel2);
`else
        tick_n(20);
        check_eq("noauto_mask", int'(spinning), 7);
        check_eq("noauto_stop", int'(stop), 0);
        check_eq("noauto_reel0", int'(reel0), 1);
        repeat (3) press(2, 1);
        check_eq("noauto_done", int'(spinning), 0);
        $display("no auto-stop: reels still spinning after 20 ticks");
`endif
        check_eq("zero_final_credit", int'(credit_z), 0);
        check_eq("zero_final_stop", int'(stop_z), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
